// File: rtl/pixel_classifier.sv
// RGB565 pixel classifier: tracks frame coordinates, maps each pixel to a 4-bit
// colour code and issues single-cycle writes into the colour history memory.
module pixel_classifier #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHROMA_MIN = 12,
    parameter int WHITE_MIN  = 150,
    parameter int BLACK_MAX  = 30,
    parameter int PAIR_TOL   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hist_ready,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic       pix_eol,
    input  logic [4:0] pix_r,
    input  logic [5:0] pix_g,
    input  logic [4:0] pix_b,
    output logic [9:0] write_x,
    output logic [9:0] write_y,
    output logic [3:0] write_data,
    output logic       write_en,
    output logic       frame_done,
    output logic       overflow
);

    localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM      = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE - 1);
    localparam logic [7:0]  CHROMA_LIM = 8'(CHROMA_MIN);
    localparam logic [7:0]  WHITE_LIM  = 8'(WHITE_MIN);
    localparam logic [7:0]  BLACK_LIM  = 8'(BLACK_MAX);
    localparam logic [6:0]  PAIR_LIM   = 7'(PAIR_TOL);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        C_NONE    = 4'd0,
        C_RED     = 4'd1,
        C_GREEN   = 4'd2,
        C_BLUE    = 4'd3,
        C_YELLOW  = 4'd4,
        C_CYAN    = 4'd5,
        C_MAGENTA = 4'd6,
        C_WHITE   = 4'd7,
        C_BLACK   = 4'd8
    } code_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    state_e      state_q, state_d;
    logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic        overflow_q, overflow_d;
    logic        sof_acc, take, in_range, wq, last_eol;
    logic [9:0]  px, py;

    // S1
    logic [5:0]  r1_q, g1_q, b1_q;
    logic [9:0]  x1_q, y1_q;
    logic        v1_q, fd1_q;
    // S2
    logic [5:0]  r2_q, g2_q, b2_q, max2_q, chroma2_q;
    logic [7:0]  sum2_q;
    logic [9:0]  x2_q, y2_q;
    logic        v2_q, fd2_q;
    logic [5:0]  max6, min6;
    logic [7:0]  sum8;
    // S3
    logic [9:0]  write_x_q, write_y_q;
    logic [3:0]  write_data_q;
    logic        write_en_q, frame_done_q;
    logic [5:0]  second;
    logic [3:0]  solo_code, pair_code, code;

    // NOTE: every variable gets a default at the top of each always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sof_acc  = pix_valid & pix_sof & hist_ready;
        take     = sof_acc | ((state_q == ACTIVE) & pix_valid);
        px       = sof_acc ? 10'd0 : x_cnt_q;
        py       = sof_acc ? 10'd0 : y_cnt_q;
        in_range = ({1'b0, px} < H_LIM) && ({1'b0, py} < V_LIM);
        wq       = take & hist_ready & in_range;
        last_eol = take & hist_ready & pix_eol & ({1'b0, py} == V_LAST);

        state_d = state_q;
        if (sof_acc) begin
            state_d = ACTIVE;
        end else if ((state_q == ACTIVE) && (!hist_ready || frame_done_q)) begin
            state_d = WAIT_SOF;
        end

        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (take) begin
            if (pix_eol) begin
                x_cnt_d = 10'd0;
                y_cnt_d = sat_inc(py);
            end else begin
                x_cnt_d = sat_inc(px);
                y_cnt_d = py;
            end
        end

        overflow_d = overflow_q;
        if (sof_acc) begin
            overflow_d = 1'b0;
        end
        if (take && hist_ready && !in_range) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        max6 = r1_q;
        min6 = r1_q;
        if (g1_q > max6) max6 = g1_q;
        if (b1_q > max6) max6 = b1_q;
        if (g1_q < min6) min6 = g1_q;
        if (b1_q < min6) min6 = b1_q;
        sum8 = {2'b00, r1_q} + {2'b00, g1_q} + {2'b00, b1_q};
    end

    // Dominant channel ties resolve R > G > B; equal runners-up follow the same order.
    always_comb begin
        second    = 6'd0;
        solo_code = C_NONE;
        pair_code = C_NONE;
        code      = C_NONE;
        if (r2_q == max2_q) begin
            solo_code = C_RED;
            if (g2_q >= b2_q) begin second = g2_q; pair_code = C_YELLOW;  end
            else              begin second = b2_q; pair_code = C_MAGENTA; end
        end else if (g2_q == max2_q) begin
            solo_code = C_GREEN;
            if (r2_q >= b2_q) begin second = r2_q; pair_code = C_YELLOW;  end
            else              begin second = b2_q; pair_code = C_CYAN;    end
        end else begin
            solo_code = C_BLUE;
            if (r2_q >= g2_q) begin second = r2_q; pair_code = C_MAGENTA; end
            else              begin second = g2_q; pair_code = C_CYAN;    end
        end

        if ({2'b00, chroma2_q} < CHROMA_LIM) begin
            if (sum2_q >= WHITE_LIM)      code = C_WHITE;
            else if (sum2_q <= BLACK_LIM) code = C_BLACK;
            else                          code = C_NONE;
        end else if (({1'b0, second} + PAIR_LIM) >= {1'b0, max2_q}) begin
            code = pair_code;
        end else begin
            code = solo_code;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            x_cnt_q      <= 10'd0;
            y_cnt_q      <= 10'd0;
            overflow_q   <= 1'b0;
            v1_q         <= 1'b0;
            fd1_q        <= 1'b0;
            v2_q         <= 1'b0;
            fd2_q        <= 1'b0;
            write_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
            write_x_q    <= 10'd0;
            write_y_q    <= 10'd0;
            write_data_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            overflow_q   <= overflow_d;
            v1_q         <= wq;
            fd1_q        <= last_eol;
            v2_q         <= v1_q;
            fd2_q        <= fd1_q;
            write_en_q   <= v2_q;
            frame_done_q <= fd2_q;
            if (v2_q) begin
                write_x_q    <= x2_q;
                write_y_q    <= y2_q;
                write_data_q <= code;
            end
        end
    end

    // NOTE: datapath stages carry no reset; they are only observed through the
    // reset valid bits, so clearing them would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        r1_q      <= {pix_r, pix_r[4]};
        g1_q      <= pix_g;
        b1_q      <= {pix_b, pix_b[4]};
        x1_q      <= px;
        y1_q      <= py;
        r2_q      <= r1_q;
        g2_q      <= g1_q;
        b2_q      <= b1_q;
        max2_q    <= max6;
        chroma2_q <= max6 - min6;
        sum2_q    <= sum8;
        x2_q      <= x1_q;
        y2_q      <= y1_q;
    end

    assign write_x    = write_x_q;
    assign write_y    = write_y_q;
    assign write_data = write_data_q;
    assign write_en   = write_en_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule
